// File: rtl/bp_pkg.sv
// Shared types, counter encodings and saturating helpers for the branch history table.
package bp_pkg;

  // Widest counter the helpers handle; counters are zero-extended to this width.
  localparam int CNT_MAX_W = 16;

  // Widest tag the entry struct holds (a 2-entry table leaves 29 tag bits).
  localparam int TAG_MAX_W = 29;

  // 2-bit counter encodings; the MSB set means predict taken.
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef logic [CNT_MAX_W-1:0] cnt_ext_t;

  // One table entry; narrower tags are stored zero-extended in the tag field.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
  } bp_entry_t;

  // Increment that holds at maxv instead of wrapping.
  function automatic cnt_ext_t sat_inc(input cnt_ext_t v, input cnt_ext_t maxv);
    return (v >= maxv) ? maxv : v + cnt_ext_t'(1);
  endfunction

  // Decrement that holds at zero instead of wrapping.
  function automatic cnt_ext_t sat_dec(input cnt_ext_t v);
    return (v == '0) ? '0 : v - cnt_ext_t'(1);
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One CNT_W-bit saturating up/down counter with a direct load for allocation.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] rst_val,
  output logic [CNT_W-1:0] q
);

  localparam cnt_ext_t MAXV = cnt_ext_t'({CNT_W{1'b1}});

  logic [CNT_W-1:0] q_next;
  cnt_ext_t         q_ext;

  // Next value: a load wins, otherwise step towards taken or not-taken and stick at the ends.
  always_comb begin
    q_ext  = cnt_ext_t'(q);
    q_next = q;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      q_next = up ? CNT_W'(sat_inc(q_ext, MAXV)) : CNT_W'(sat_dec(q_ext));
    end
  end

  // Counter register with synchronous reset to the caller-supplied value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= rst_val;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history/target table: combinational lookup in ID, training from MEM.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [31:0]       lookup_pc4,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc4,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispredict,
  output logic [PERF_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Weak-taken is MSB set with the rest clear; weak-not-taken is one below it.
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(CNT_WT) << (CNT_W - 2);
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);

  bp_entry_t        bht_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  bp_entry_t        lk_entry;
  logic [CNT_W-1:0] lk_cnt;
  logic             lk_hit;
  logic             unused_pc_lsbs;

  assign lk_idx  = lookup_pc4[IDX_W+1:2];
  assign lk_tag  = lookup_pc4[31:IDX_W+2];
  assign upd_idx = upd_pc4[IDX_W+1:2];
  assign upd_tag = upd_pc4[31:IDX_W+2];

  // Byte-offset bits never select an entry.
  assign unused_pc_lsbs = ^{lookup_pc4[1:0], upd_pc4[1:0]};

  assign upd_hit = bht_q[upd_idx].valid & (bht_q[upd_idx].tag == TAG_MAX_W'(upd_tag));

  // Lookup reads the registered table, so a same-cycle update is only seen next cycle.
  always_comb begin
    lk_entry    = bht_q[lk_idx];
    lk_cnt      = cnt_q[lk_idx];
    lk_hit      = lookup_valid & lk_entry.valid & (lk_entry.tag == TAG_MAX_W'(lk_tag));
    pred_hit    = lk_hit;
    pred_taken  = lk_hit & lk_cnt[CNT_W-1];
    pred_target = pred_taken ? lk_entry.target : lookup_pc4;
  end

  // One counter per entry: trained on a tag hit, loaded weak-taken when a taken miss allocates.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = upd_valid & (upd_idx == IDX_W'(i));

    bp_sat_ctr #(
      .CNT_W(CNT_W)
    ) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (sel & upd_hit),
      .up       (upd_taken),
      .load     (sel & ~upd_hit & upd_taken),
      .load_val (CNT_WEAK_T),
      .rst_val  (CNT_WEAK_NT),
      .q        (cnt_q[i])
    );
  end

  // Taken updates refresh the target; a taken miss also claims the slot for the new tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_q[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      bht_q[upd_idx].target <= upd_target;
      if (!upd_hit) begin
        bht_q[upd_idx].valid <= 1'b1;
        bht_q[upd_idx].tag   <= TAG_MAX_W'(upd_tag);
      end
    end
  end

  // Free-running mispredict counter that wraps at its width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mispredict_cnt <= '0;
    end else if (upd_valid && upd_mispredict) begin
      mispredict_cnt <= mispredict_cnt + PERF_W'(1);
    end
  end

endmodule
